// File: rtl/pipe_stage_buf.sv
// Generic pipeline-stage register with valid/ready handshake, flush and saturating stall counter.
// State updates on the falling clock edge. Define PIPE_BUF_SKID_EN for the 2-entry skid variant with registered o_ready.
module pipe_stage_buf #(
  parameter int                DATA_W  = 32,
  parameter int                CNT_W   = 16,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  logic              w_accept;
  logic              w_drain;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_accept    = i_valid & o_ready;
  assign w_drain     = o_valid & i_ready;
  assign o_data      = r_data;
  assign o_stall_cnt = r_stall_cnt;

`ifdef PIPE_BUF_SKID_EN
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_skid_data;
  logic              w_load_main;
  logic              w_load_skid;
  logic              w_skid_to_main;

  // o_ready depends only on the state register, breaking the i_ready path upstream
  assign o_valid = (r_state != ST_EMPTY);
  assign o_ready = (r_state != ST_TWO);

  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && !w_drain) begin
          w_state_nxt = ST_TWO;
          w_load_skid = 1'b1;
        end else if (w_accept && w_drain) begin
          w_load_main = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_drain) begin
          w_state_nxt    = ST_ONE;
          w_skid_to_main = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst || i_flush) begin
      r_state     <= ST_EMPTY;
      r_data      <= RST_VAL;
      r_skid_data <= RST_VAL;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main)
        r_data <= i_data;
      else if (w_skid_to_main)
        r_data <= r_skid_data;
      if (w_load_skid)
        r_skid_data <= i_data;
    end
  end
`else
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_load_main;

  assign o_valid = (r_state == ST_FULL);
  assign o_ready = ~o_valid | i_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load_main = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
          w_load_main = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_accept) begin
          w_load_main = 1'b1;
        end else if (w_drain) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(negedge clk) begin
    if (rst || i_flush) begin
      r_state <= ST_EMPTY;
      r_data  <= RST_VAL;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_main)
        r_data <= i_data;
    end
  end
`endif

  // flush leaves the counter alone; only rst clears it
  always_ff @(negedge clk) begin
    if (rst)
      r_stall_cnt <= '0;
    else if (!i_flush && o_valid && !i_ready && (r_stall_cnt != {CNT_W{1'b1}}))
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed checks plus randomized traffic against a queue model.
module tb_pipe_stage_buf;

`ifdef PIPE_BUF_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, i_flush, i_valid, i_ready;
  logic [31:0] i_data;
  logic        o_ready, o_valid;
  logic [31:0] o_data;
  logic [15:0] o_stall_cnt;
  logic        s_ready, s_valid;
  logic [31:0] s_data;
  logic [2:0]  s_stall_cnt;

  int n_cmp = 0;
  int n_err = 0;
  bit en    = 1'b0;

  pipe_stage_buf #(.DATA_W(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_stall_cnt(o_stall_cnt)
  );

  pipe_stage_buf #(.DATA_W(32), .CNT_W(3)) u_sat (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(s_ready),
    .i_data(i_data), .o_valid(s_valid), .i_ready(i_ready), .o_data(s_data),
    .o_stall_cnt(s_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of capacity 1 (base) or 2 (skid)
  logic [31:0] mq[$];
  int          m_cnt;
  int          m_cnt3;
  bit          m_clean;

  always @(negedge clk) begin
    int sz;
    bit rdy, acc, drn;
    sz  = mq.size();
    rdy = SKID ? (sz < 2) : (sz == 0 || i_ready);
    acc = i_valid && rdy;
    drn = (sz > 0) && i_ready;
    if (rst) begin
      mq.delete();
      m_cnt   = 0;
      m_cnt3  = 0;
      m_clean = 1'b1;
    end else if (i_flush) begin
      mq.delete();
      m_clean = 1'b1;
    end else begin
      if (sz > 0 && !i_ready) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt3 < 7) m_cnt3++;
      end
      if (drn) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(i_data);
        m_clean = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (en) begin
      chk("m_valid", {31'd0, o_valid}, {31'd0, mq.size() > 0});
      chk("m_ready", {31'd0, o_ready},
          {31'd0, SKID ? (mq.size() < 2) : (mq.size() == 0 || i_ready)});
      if (mq.size() > 0) chk("m_data", o_data, mq[0]);
      else if (m_clean) chk("m_data_rst", o_data, 32'd0);
      chk("m_cnt", {16'd0, o_stall_cnt}, m_cnt);
      chk("m_cnt3", {29'd0, s_stall_cnt}, m_cnt3);
      chk("m_sat_valid", {31'd0, s_valid}, {31'd0, mq.size() > 0});
    end
  end

  task automatic cyc(input bit r, input bit f, input bit v, input logic [31:0] d, input bit rd);
    @(posedge clk);
    rst = r; i_flush = f; i_valid = v; i_data = d; i_ready = rd;
    @(negedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_data = '0; i_ready = 1'b0;

    cyc(1, 0, 1, 32'hDEAD, 0);
    en = 1'b1;
    cyc(1, 0, 1, 32'hDEAD, 0);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_data", o_data, 32'd0);
    chk("rst_cnt", {16'd0, o_stall_cnt}, 32'd0);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);

    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 1, k, 1);
      chk("stream_data", o_data, k);
      chk("stream_valid", {31'd0, o_valid}, 32'd1);
    end
    cyc(0, 0, 0, 0, 1);
    chk("stream_empty", {31'd0, o_valid}, 32'd0);

    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'hA5, 0);
    chk("bp_load", o_data, 32'hA5);
    for (int i = 0; i < 5; i++) cyc(0, 0, (i == 0), 32'h5A, 0);
    chk("bp_data", o_data, 32'hA5);
    chk("bp_cnt", {16'd0, o_stall_cnt}, 32'd5);
    chk("bp_ready", {31'd0, o_ready}, 32'd0);
    cyc(0, 0, 0, 0, 1);
    chk("bp_rel_valid", {31'd0, o_valid}, {31'd0, SKID});
    chk("bp_rel_data", o_data, SKID ? 32'h5A : 32'hA5);
    cyc(0, 0, 0, 0, 1);
    chk("bp_rel_empty", {31'd0, o_valid}, 32'd0);
    chk("bp_rel_cnt", {16'd0, o_stall_cnt}, 32'd5);

    cyc(0, 0, 1, 32'h11, 0);
    cyc(0, 1, 1, 32'h7, 0);
    chk("fl_valid", {31'd0, o_valid}, 32'd0);
    chk("fl_data", o_data, 32'd0);
    chk("fl_cnt", {16'd0, o_stall_cnt}, 32'd5);
    cyc(0, 0, 0, 0, 0);
    chk("fl_dropped", {31'd0, o_valid}, 32'd0);

    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h22, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
    chk("sat_cnt3", {29'd0, s_stall_cnt}, 32'd7);
    chk("sat_cnt16", {16'd0, o_stall_cnt}, 32'd10);

    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h31, 0);
    cyc(0, 0, 1, 32'h32, 0);
    chk("mid_ready_full", {31'd0, o_ready}, 32'd0);
    cyc(1, 0, 1, 32'h33, 0);
    chk("mid_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_ready", {31'd0, o_ready}, 32'd1);
    chk("mid_data", o_data, 32'd0);
    cyc(0, 0, 0, 0, 1);
    chk("mid_empty", {31'd0, o_valid}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 3),
          ($urandom_range(0, 99) < 70), $urandom, ($urandom_range(0, 99) < 60));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
